id_ex_fwd: RTL
==============

ID_EX_FWD -- requirements
Module: id_ex_fwd

Interface
REQ-001 SHALL provide: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL provide: rst  in  1  synchronous reset, active-low (`RstEnable` = 1'b0); sampled only on clk rising edge.
REQ-003 SHALL provide: inst_i  in  32  ID-stage instruction.
REQ-004 SHALL provide: inst_addr_i  in  32  ID-stage instruction address.
REQ-005 SHALL provide: reg1_rdata_i / reg2_rdata_i  in  32 each  regfile read data.
REQ-006 SHALL provide: reg_we_i  in  1; reg_waddr_i  in  5  ID destination write enable and address.
REQ-007 SHALL provide: fwd_reg1_i / fwd_reg2_i  in  1 each  forward selects from hazard control (EX-to-ID match).
REQ-008 SHALL provide: ex_fwd_data_i  in  32  EX result; ex_is_load_i  in  1  EX instruction is a load (result not yet valid).
REQ-009 SHALL provide: mem_fwd_data_i  in  32  MEM-stage load data.
REQ-010 SHALL provide: hold_i  in  1  freeze register; flush_i  in  1  jump/branch kill.
REQ-011 SHALL provide: inst_o, inst_addr_o, reg1_rdata_o, reg2_rdata_o  out  32 each; reg_we_o  out  1; reg_waddr_o  out  5; valid_o  out  1  EX-stage payload.
REQ-012 SHALL provide: stall_id_o  out  1  combinational request to freeze PC and IF/ID.
REQ-013 SHALL provide: stall_cnt_o  out  32  bubble counter (see Configuration).

Function
REQ-014 Operand select, state NORMAL: operand n = ex_fwd_data_i when fwd_regn_i=1 and ex_is_load_i=0, else regn_rdata_i.
REQ-015 Load-use: in NORMAL, (fwd_reg1_i|fwd_reg2_i) & ex_is_load_i SHALL assert stall_id_o the same cycle, load a bubble, latch which operands matched, go to LOAD_WAIT.
REQ-016 Bubble: inst_o=32'h00000001 (NOP), inst_addr_o=0, reg1/reg2_rdata_o=0, reg_we_o=0, reg_waddr_o=0, valid_o=0.
REQ-017 LOAD_WAIT (exactly one cycle): stall_id_o=0; latched operands take mem_fwd_data_i, others regn_rdata_i (fwd_regn_i/ex_fwd_data_i ignored); ID payload registered with valid_o=1; return to NORMAL.
REQ-018 Normal advance: register ID payload with valid_o=1, latency one cycle ID-to-EX.
REQ-019 Priority each edge: rst > flush_i > hold_i > load-use > normal.
REQ-020 flush_i=1: load bubble, state to NORMAL, clear latched selects, stall_id_o=0, regardless of hold_i or load-use.
REQ-021 hold_i=1 (no flush): all outputs and state keep value; stall_id_o=0; LOAD_WAIT not consumed while held; mem operand re-sampled on the releasing edge.
REQ-022 Load-use with zero register never arises (hazard control excludes x0); block SHALL NOT re-check.
REQ-023 Back-to-back load-use (new match in cycle after LOAD_WAIT) SHALL insert a fresh bubble.

Reset
REQ-024 rst=0 at rising edge: all outputs to bubble values (REQ-016), state NORMAL, latched selects 0, stall_cnt_o=0.
REQ-025 Reset during LOAD_WAIT or hold SHALL abandon the pending operation; stall_id_o=0 while rst=0.

Configuration
REQ-026 Macro ID_EX_STALL_CNT_EN defined: stall_cnt_o counts cycles where a load-use bubble is inserted, +1 per bubble, saturating at 32'hFFFFFFFF, not incremented on flush or hold.
REQ-027 ID_EX_STALL_CNT_EN undefined: no counter flops; stall_cnt_o tied to 32'h0.

Verification
REQ-028 Forward: fwd_reg1_i=1, ex_is_load_i=0, ex_fwd_data_i=32'hDEAD0001, reg1_rdata_i=5 -> next cycle reg1_rdata_o=32'hDEAD0001, valid_o=1, stall_id_o=0 throughout.
REQ-029 Load-use: fwd_reg2_i=1, ex_is_load_i=1 -> stall_id_o=1 that cycle, next cycle inst_o=32'h00000001/valid_o=0; following cycle mem_fwd_data_i=32'h12345678 -> reg2_rdata_o=32'h12345678, valid_o=1.
REQ-030 Flush beats hold and load-use: flush_i=1, hold_i=1, load-use condition true -> next cycle bubble, stall_id_o=0, stall_cnt_o unchanged.
REQ-031 Hold in LOAD_WAIT: hold_i=1 for 3 cycles -> outputs frozen; release with mem_fwd_data_i=32'hCAFE -> latched operand = 32'hCAFE.
REQ-032 Reset mid-stall: rst=0 in LOAD_WAIT -> next cycle all outputs bubble, stall_cnt_o=0; with ID_EX_STALL_CNT_EN, 2 load-use bubbles -> stall_cnt_o=2; without macro -> stall_cnt_o=0.

Source files
------------

// File: rtl/id_ex_fwd.sv
// ============================================================================
// Module      : id_ex_fwd
// Description : ID/EX pipeline register with EX forwarding and load-use stall.
//               Optional bubble counter enabled by macro ID_EX_STALL_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_fwd (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_i,
    input  logic [31:0] inst_addr_i,
    input  logic [31:0] reg1_rdata_i,
    input  logic [31:0] reg2_rdata_i,
    input  logic        reg_we_i,
    input  logic [4:0]  reg_waddr_i,
    input  logic        fwd_reg1_i,
    input  logic        fwd_reg2_i,
    input  logic [31:0] ex_fwd_data_i,
    input  logic        ex_is_load_i,
    input  logic [31:0] mem_fwd_data_i,
    input  logic        hold_i,
    input  logic        flush_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic [31:0] reg1_rdata_o,
    output logic [31:0] reg2_rdata_o,
    output logic        reg_we_o,
    output logic [4:0]  reg_waddr_o,
    output logic        valid_o,
    output logic        stall_id_o,
    output logic [31:0] stall_cnt_o
);

    typedef enum logic [0:0] {
        ST_NORMAL    = 1'b0,
        ST_LOAD_WAIT = 1'b1
    } state_t;

    localparam logic [31:0] C_NOP_INST = 32'h0000_0001;

    state_t      r_state_q,     w_state_d;
    logic        r_lat1_q,      w_lat1_d;
    logic        r_lat2_q,      w_lat2_d;
    logic [31:0] r_inst_q,      w_inst_d;
    logic [31:0] r_addr_q,      w_addr_d;
    logic [31:0] r_op1_q,       w_op1_d;
    logic [31:0] r_op2_q,       w_op2_d;
    logic        r_we_q,        w_we_d;
    logic [4:0]  r_waddr_q,     w_waddr_d;
    logic        r_valid_q,     w_valid_d;

    logic        w_load_use;
    logic        w_bubble;
    logic        w_stall;

    assign w_load_use = (fwd_reg1_i | fwd_reg2_i) & ex_is_load_i;

    always_comb begin
        w_state_d = r_state_q;
        w_lat1_d  = r_lat1_q;
        w_lat2_d  = r_lat2_q;
        w_inst_d  = r_inst_q;
        w_addr_d  = r_addr_q;
        w_op1_d   = r_op1_q;
        w_op2_d   = r_op2_q;
        w_we_d    = r_we_q;
        w_waddr_d = r_waddr_q;
        w_valid_d = r_valid_q;
        w_bubble  = 1'b0;
        w_stall   = 1'b0;

        if (flush_i) begin
            w_bubble  = 1'b1;
            w_state_d = ST_NORMAL;
            w_lat1_d  = 1'b0;
            w_lat2_d  = 1'b0;
        end else if (!hold_i) begin
            w_inst_d  = inst_i;
            w_addr_d  = inst_addr_i;
            w_we_d    = reg_we_i;
            w_waddr_d = reg_waddr_i;
            w_valid_d = 1'b1;
            if (r_state_q == ST_LOAD_WAIT) begin
                // Load data is now in MEM; EX-side forwarding is stale here.
                w_op1_d   = r_lat1_q ? mem_fwd_data_i : reg1_rdata_i;
                w_op2_d   = r_lat2_q ? mem_fwd_data_i : reg2_rdata_i;
                w_state_d = ST_NORMAL;
                w_lat1_d  = 1'b0;
                w_lat2_d  = 1'b0;
            end else if (w_load_use) begin
                w_stall   = 1'b1;
                w_bubble  = 1'b1;
                w_state_d = ST_LOAD_WAIT;
                w_lat1_d  = fwd_reg1_i;
                w_lat2_d  = fwd_reg2_i;
            end else begin
                w_op1_d   = (fwd_reg1_i && !ex_is_load_i) ? ex_fwd_data_i : reg1_rdata_i;
                w_op2_d   = (fwd_reg2_i && !ex_is_load_i) ? ex_fwd_data_i : reg2_rdata_i;
            end
        end

        if (w_bubble) begin
            w_inst_d  = C_NOP_INST;
            w_addr_d  = 32'h0;
            w_op1_d   = 32'h0;
            w_op2_d   = 32'h0;
            w_we_d    = 1'b0;
            w_waddr_d = 5'h0;
            w_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state_q <= ST_NORMAL;
            r_lat1_q  <= 1'b0;
            r_lat2_q  <= 1'b0;
            r_inst_q  <= C_NOP_INST;
            r_addr_q  <= 32'h0;
            r_op1_q   <= 32'h0;
            r_op2_q   <= 32'h0;
            r_we_q    <= 1'b0;
            r_waddr_q <= 5'h0;
            r_valid_q <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_lat1_q  <= w_lat1_d;
            r_lat2_q  <= w_lat2_d;
            r_inst_q  <= w_inst_d;
            r_addr_q  <= w_addr_d;
            r_op1_q   <= w_op1_d;
            r_op2_q   <= w_op2_d;
            r_we_q    <= w_we_d;
            r_waddr_q <= w_waddr_d;
            r_valid_q <= w_valid_d;
        end
    end

    // A stall is raised exactly on the cycles a load-use bubble is loaded.
    assign stall_id_o   = rst & w_stall;
    assign inst_o       = r_inst_q;
    assign inst_addr_o  = r_addr_q;
    assign reg1_rdata_o = r_op1_q;
    assign reg2_rdata_o = r_op2_q;
    assign reg_we_o     = r_we_q;
    assign reg_waddr_o  = r_waddr_q;
    assign valid_o      = r_valid_q;

`ifdef ID_EX_STALL_CNT_EN
    logic [31:0] r_stall_cnt_q, w_stall_cnt_d;

    always_comb begin
        w_stall_cnt_d = r_stall_cnt_q;
        if (stall_id_o && (r_stall_cnt_q != 32'hFFFF_FFFF)) begin
            w_stall_cnt_d = r_stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cnt_q <= 32'h0;
        end else begin
            r_stall_cnt_q <= w_stall_cnt_d;
        end
    end

    assign stall_cnt_o = r_stall_cnt_q;
`else
    assign stall_cnt_o = 32'h0;
`endif

endmodule

`default_nettype wire
